// File: rtl/chan_pkg.sv
// Shared types, default thresholds and widths for the Gilbert-Elliott bit channel scheduler.
package chan_pkg;

  localparam int RAND_W   = 7;
  localparam int BURST_W  = 8;
  localparam int STAT_W   = 16;
  localparam int RAND_MAX = (1 << RAND_W) - 1;

  localparam int G2B_THR_DEF      = 97;
  localparam int B2G_THR_DEF      = 75;
  localparam int ERR_THR_GOOD_DEF = 21;
  localparam int ERR_THR_BAD_DEF  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_OUT  = 2'd2
  } fsm_e;

  typedef enum logic {
    CH_GOOD = 1'b0,
    CH_BAD  = 1'b1
  } chan_e;

  // A zero threshold always hits and an out-of-range threshold never does, for both rule forms.
  function automatic logic thr_ge(input logic [RAND_W-1:0] v, input int thr);
    if (thr == 0) return 1'b1;
    if (thr > RAND_MAX) return 1'b0;
    return int'({{(32-RAND_W){1'b0}}, v}) >= thr;
  endfunction

  function automatic logic thr_lt(input logic [RAND_W-1:0] v, input int thr);
    if (thr == 0) return 1'b1;
    if (thr > RAND_MAX) return 1'b0;
    return int'({{(32-RAND_W){1'b0}}, v}) < thr;
  endfunction

endpackage

// File: rtl/chan_stats.sv
// Saturating symbol and error counters with a synchronous clear that overrides counting.
module chan_stats
  import chan_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              err_i,
  output logic [STAT_W-1:0] sym_count_o,
  output logic [STAT_W-1:0] err_count_o
);

  logic [STAT_W-1:0] sym_q, err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      sym_q <= '0;
      err_q <= '0;
    end else if (inc_i) begin
      if (!(&sym_q)) sym_q <= sym_q + STAT_W'(1);
      if (err_i && !(&err_q)) err_q <= err_q + STAT_W'(1);
    end
  end

  assign sym_count_o = sym_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/channel_scheduler.sv
// Two-state burst-error channel applied to a bit stream, drawing randomness from an external source.
// Optional statistics counters are built when CHAN_STATS_EN is defined.
module channel_scheduler
  import chan_pkg::*;
#(
  parameter int G2B_THR      = G2B_THR_DEF,
  parameter int B2G_THR      = B2G_THR_DEF,
  parameter int ERR_THR_GOOD = ERR_THR_GOOD_DEF,
  parameter int ERR_THR_BAD  = ERR_THR_BAD_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               chan_en_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_bit_i,
  output logic               rand_req_o,
  input  logic               rand_valid_i,
  input  logic [RAND_W-1:0]  rand_state_i,
  input  logic [RAND_W-1:0]  rand_err_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_bit_o,
  output logic               out_err_o,
  output logic               chan_state_o,
  output logic [BURST_W-1:0] burst_len_o
`ifdef CHAN_STATS_EN
  ,
  input  logic               stats_clr_i,
  output logic [STAT_W-1:0]  sym_count_o,
  output logic [STAT_W-1:0]  err_count_o
`endif
);

  fsm_e               state_q;
  chan_e              chan_q, chan_d;
  logic               bit_q;
  logic               in_ready_q, rand_req_q, out_valid_q, out_bit_q, out_err_q;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               err_d;
  logic               out_hs;

  assign out_hs = out_valid_q & out_ready_i;

  // Flip rule uses the state before this draw's transition.
  always_comb begin
    err_d = chan_en_i & ((chan_q == CH_BAD) ? thr_ge(rand_err_i, ERR_THR_BAD)
                                            : thr_lt(rand_err_i, ERR_THR_GOOD));
    chan_d = chan_q;
    if (chan_en_i) begin
      if (chan_q == CH_GOOD && thr_ge(rand_state_i, G2B_THR))     chan_d = CH_BAD;
      else if (chan_q == CH_BAD && thr_ge(rand_state_i, B2G_THR)) chan_d = CH_GOOD;
    end
    burst_d = '0;
    if (out_err_q) burst_d = (&burst_q) ? burst_q : burst_q + BURST_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      chan_q      <= CH_GOOD;
      bit_q       <= 1'b0;
      burst_q     <= '0;
      in_ready_q  <= 1'b1;
      rand_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid_i) begin
          bit_q      <= in_bit_i;
          in_ready_q <= 1'b0;
          rand_req_q <= 1'b1;
          state_q    <= ST_DRAW;
        end
        ST_DRAW: if (rand_valid_i) begin
          out_err_q   <= err_d;
          out_bit_q   <= bit_q ^ err_d;
          chan_q      <= chan_d;
          rand_req_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: if (out_ready_i) begin
          burst_q     <= burst_d;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          rand_req_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign rand_req_o   = rand_req_q;
  assign out_valid_o  = out_valid_q;
  assign out_bit_o    = out_bit_q;
  assign out_err_o    = out_err_q;
  assign chan_state_o = chan_q;
  assign burst_len_o  = burst_q;

`ifdef CHAN_STATS_EN
  chan_stats u_stats (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (stats_clr_i),
    .inc_i       (out_hs),
    .err_i       (out_err_q),
    .sym_count_o (sym_count_o),
    .err_count_o (err_count_o)
  );
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_channel_scheduler.sv
// Scoreboard bench for channel_scheduler: directed scenarios plus random traffic against a channel model.
module tb_channel_scheduler;
  import chan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, chan_en = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic       rand_valid = 1'b0, out_ready = 1'b0;
  logic [6:0] rand_state = '0, rand_err = '0;
  logic       in_ready, rand_req, out_valid, out_bit, out_err, chan_state;
  logic [7:0] burst_len;
`ifdef CHAN_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] sym_count, err_count;
`endif

  channel_scheduler dut (
    .clk_i(clk), .reset_i(rst), .chan_en_i(chan_en),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_bit_i(in_bit),
    .rand_req_o(rand_req), .rand_valid_i(rand_valid),
    .rand_state_i(rand_state), .rand_err_i(rand_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_bit_o(out_bit), .out_err_o(out_err),
    .chan_state_o(chan_state), .burst_len_o(burst_len)
`ifdef CHAN_STATS_EN
    , .stats_clr_i(stats_clr), .sym_count_o(sym_count), .err_count_o(err_count)
`endif
  );

  typedef struct {
    logic b;
    logic e;
    logic st;
    int   burst;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  logic m_bad = 1'b0;
  int   m_burst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Threshold rules as stated for the channel: 0 always hits, above 127 never does.
  function automatic logic ge_rule(input int v, input int thr);
    if (thr == 0) return 1'b1;
    if (thr > 127) return 1'b0;
    return v >= thr;
  endfunction

  function automatic logic lt_rule(input int v, input int thr);
    if (thr == 0) return 1'b1;
    if (thr > 127) return 1'b0;
    return v < thr;
  endfunction

  task automatic model(input logic b, input logic en, input int rs, input int re, output exp_t x);
    logic flip, err;
    flip = m_bad ? ge_rule(re, ERR_THR_BAD_DEF) : lt_rule(re, ERR_THR_GOOD_DEF);
    err  = flip & en;
    if (en) begin
      if (!m_bad && ge_rule(rs, G2B_THR_DEF))     m_bad = 1'b1;
      else if (m_bad && ge_rule(rs, B2G_THR_DEF)) m_bad = 1'b0;
    end
    m_burst = err ? ((m_burst < 255) ? m_burst + 1 : 255) : 0;
    x.b = b ^ err;
    x.e = err;
    x.st = m_bad;
    x.burst = m_burst;
  endtask

  // Monitor: samples just after the falling edge, when inputs for the coming rising edge are settled.
  logic pend = 1'b0;
  int   pend_burst = 0;
  always @(negedge clk) begin
    exp_t x;
    #1;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        chk("burst_len", burst_len, pend_burst);
        pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got output with empty scoreboard at %0t", $time);
        end else begin
          x = sb.pop_front();
          chk("out_bit", out_bit, x.b);
          chk("out_err", out_err, x.e);
          chk("chan_state", chan_state, x.st);
          pend = 1'b1;
          pend_burst = x.burst;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_bad = 1'b0;
    m_burst = 0;
    sb.delete();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rand_req", rand_req, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_chan_state", chan_state, 0);
    chk("rst_burst", burst_len, 0);
  endtask

  task automatic send(input logic b, input logic en, input int rs, input int re,
                      input int dd, input int dq, input logic rst_in_out);
    exp_t x;
    int   n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_bit   = b;
    chan_en  = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'($urandom);
    chan_en  = en;
    chk("draw_rand_req", rand_req, 1);
    chk("draw_in_ready", in_ready, 0);
    repeat (dd) begin
      @(negedge clk);
      chk("stall_rand_req", rand_req, 1);
      chk("stall_out_valid", out_valid, 0);
    end
    model(b, en, rs, re, x);
    sb.push_back(x);
    rand_valid = 1'b1;
    rand_state = 7'(rs);
    rand_err   = 7'(re);
    @(negedge clk);
    rand_valid = 1'b0;
    rand_state = 7'($urandom);
    rand_err   = 7'($urandom);
    chan_en    = 1'($urandom);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_rand_req", rand_req, 0);
    repeat (dq) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_bit", out_bit, x.b);
      chk("hold_out_err", out_err, x.e);
      chk("hold_in_ready", in_ready, 0);
    end
    if (rst_in_out) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_bad = 1'b0;
      m_burst = 0;
      sb.delete();
      chk("rout_in_ready", in_ready, 1);
      chk("rout_out_valid", out_valid, 0);
      chk("rout_chan_state", chan_state, 0);
      chk("rout_burst", burst_len, 0);
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    send(1'b1, 1'b1, 10, 50, 0, 0, 1'b0);
    send(1'b0, 1'b1, 97, 5, 0, 0, 1'b0);
    send(1'b1, 1'b1, 74, 9, 0, 0, 1'b0);
    send(1'b0, 1'b1, 75, 3, 0, 0, 1'b0);
    send(1'b1, 1'b1, 20, 60, 5, 4, 1'b0);
    for (int i = 0; i < 300; i++) send(1'($urandom), 1'b1, 0, 0, 0, 0, 1'b0);
    send(1'b1, 1'b1, 0, 50, 0, 0, 1'b0);
    send(1'b1, 1'b0, 127, 0, 1, 1, 1'b0);
    send(1'b0, 1'b0, 127, 0, 0, 0, 1'b0);
    send(1'b0, 1'b1, 127, 60, 0, 0, 1'b0);
    send(1'b1, 1'b1, 10, 0, 0, 2, 1'b1);
    send(1'b1, 1'b1, 10, 50, 0, 0, 1'b0);
    for (int i = 0; i < 200; i++)
      send(1'($urandom), 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 1'b0);
`ifdef CHAN_STATS_EN
    do_reset();
    chk("stats_rst_sym", sym_count, 0);
    chk("stats_rst_err", err_count, 0);
    send(1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
    send(1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
    send(1'b1, 1'b1, 0, 50, 0, 0, 1'b0);
    @(negedge clk);
    chk("stats_sym", sym_count, 3);
    chk("stats_err", err_count, 2);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_sym", sym_count, 0);
    chk("stats_clr_err", err_count, 0);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
